// File: rtl/iter_muldiv_alu.sv
// Iterative RV32M-class multiply/divide unit: shift-add multiplier and restoring divider, one bit per clock.
// Optional macro MULDIV_EARLY_EXIT_EN ends a multiply as soon as the remaining multiplier bits are zero.
module iter_muldiv_alu #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             inValid,
    output logic             inReady,
    input  logic [7:0]       mulDivControl,
    input  logic [WIDTH-1:0] mulDivData1,
    input  logic [WIDTH-1:0] mulDivData2,
    output logic             outValid,
    input  logic             outReady,
    output logic [WIDTH-1:0] mulDivResult,
    output logic             busy,
    input  logic             flush
);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    state_t               state;
    logic [CNT_W-1:0]     cnt;
    logic [7:0]           opReg;
    logic                 negRes;
    logic [2*WIDTH-1:0]   acc;
    logic [2*WIDTH-1:0]   opA;
    logic [WIDTH-1:0]     opB;

    function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] v, input logic isSigned);
        return (isSigned && v < 0) ? WIDTH'(-v) : WIDTH'(v);
    endfunction

    function automatic logic [2*WIDTH-1:0] negWide(input logic [2*WIDTH-1:0] v, input logic neg);
        return neg ? (~v + 1'b1) : v;
    endfunction

    function automatic logic [WIDTH-1:0] negNarrow(input logic [WIDTH-1:0] v, input logic neg);
        return neg ? (~v + 1'b1) : v;
    endfunction

    logic             isMulIn, signA, signB, negIn, special;
    logic [WIDTH-1:0] magA, magB, specialRes;
    logic             isMulReg;
    logic [2*WIDTH-1:0] mulSum, prodFix;
    logic [WIDTH:0]     remShift, remTrial;

    assign inReady  = (state == IDLE);
    assign busy     = (state != IDLE);
    assign isMulReg = |opReg[3:0];

    // Request decode: operand signedness, magnitudes and the single-edge special cases
    always_comb begin
        isMulIn    = |mulDivControl[3:0];
        signA      = mulDivControl[1] | mulDivControl[2] | mulDivControl[4] | mulDivControl[6];
        signB      = mulDivControl[1] | mulDivControl[4] | mulDivControl[6];
        magA       = magnitude($signed(mulDivData1), signA);
        magB       = magnitude($signed(mulDivData2), signB);
        negIn      = 1'b0;
        if (mulDivControl[1] | mulDivControl[4])
            negIn = (signA & mulDivData1[WIDTH-1]) ^ (signB & mulDivData2[WIDTH-1]);
        else if (mulDivControl[2] | mulDivControl[6])
            negIn = mulDivData1[WIDTH-1];
        special    = 1'b0;
        specialRes = '0;
        if (!$onehot(mulDivControl)) begin
            special = 1'b1;
        end else if ((|mulDivControl[7:4]) && mulDivData2 == '0) begin
            special    = 1'b1;
            specialRes = (mulDivControl[4] | mulDivControl[5]) ? '1 : mulDivData1;
        end else if ((mulDivControl[4] | mulDivControl[6]) && mulDivData1 == MIN_NEG && (&mulDivData2)) begin
            special    = 1'b1;
            specialRes = mulDivControl[4] ? MIN_NEG : '0;
        end
    end

    // One iteration: multiply accumulates the shifted multiplicand, divide does a trial subtract
    assign mulSum   = acc + (opB[0] ? opA : {(2*WIDTH){1'b0}});
    assign remShift = {acc[WIDTH-1:0], opB[WIDTH-1]};
    assign remTrial = remShift - {1'b0, opA[WIDTH-1:0]};
    assign prodFix  = negWide(acc, negRes);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state        <= IDLE;
            cnt          <= '0;
            opReg        <= '0;
            negRes       <= 1'b0;
            acc          <= '0;
            opA          <= '0;
            opB          <= '0;
            outValid     <= 1'b0;
            mulDivResult <= '0;
        end else if (flush) begin
            if (state != IDLE) begin
                state    <= IDLE;
                outValid <= 1'b0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (inValid) begin
                        opReg  <= mulDivControl;
                        negRes <= negIn;
                        cnt    <= CNT_W'(WIDTH);
                        acc    <= '0;
                        opA    <= {{WIDTH{1'b0}}, (isMulIn ? magA : magB)};
                        opB    <= isMulIn ? magB : magA;
                        if (special) begin
                            mulDivResult <= specialRes;
                            outValid     <= 1'b1;
                            state        <= DONE;
                        end else begin
`ifdef MULDIV_EARLY_EXIT_EN
                            state <= (isMulIn && magB == '0) ? FIX : CALC;
`else
                            state <= CALC;
`endif
                        end
                    end
                end
                CALC: begin
                    cnt <= cnt - 1'b1;
                    if (isMulReg) begin
                        acc <= mulSum;
                        opA <= opA << 1;
                        opB <= opB >> 1;
                    end else if (remTrial[WIDTH]) begin
                        acc <= {{(WIDTH-1){1'b0}}, remShift};
                        opB <= {opB[WIDTH-2:0], 1'b0};
                    end else begin
                        acc <= {{(WIDTH-1){1'b0}}, remTrial};
                        opB <= {opB[WIDTH-2:0], 1'b1};
                    end
`ifdef MULDIV_EARLY_EXIT_EN
                    if (cnt == CNT_W'(1) || (isMulReg && opB[WIDTH-1:1] == '0))
                        state <= FIX;
`else
                    if (cnt == CNT_W'(1))
                        state <= FIX;
`endif
                end
                FIX: begin
                    // After the loop, opB holds the quotient and acc the product or remainder
                    if (opReg[0])
                        mulDivResult <= prodFix[WIDTH-1:0];
                    else if (isMulReg)
                        mulDivResult <= prodFix[2*WIDTH-1:WIDTH];
                    else if (|opReg[5:4])
                        mulDivResult <= negNarrow(opB, negRes);
                    else if (|opReg[7:6])
                        mulDivResult <= negNarrow(acc[WIDTH-1:0], negRes);
                    else
                        mulDivResult <= '0;
                    outValid <= 1'b1;
                    state    <= DONE;
                end
                DONE: begin
                    if (outReady) begin
                        outValid <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_iter_muldiv_alu.sv
// Self-checking bench for iter_muldiv_alu (WIDTH=32): directed and random ops against an arithmetic model.
module tb_iter_muldiv_alu;

    logic        clk = 1'b0;
    logic        rstn, inValid, inReady, outValid, outReady, busy, flush;
    logic [7:0]  mulDivControl;
    logic [31:0] mulDivData1, mulDivData2, mulDivResult;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    iter_muldiv_alu #(.WIDTH(32)) dut (
        .clk(clk), .rstn(rstn), .inValid(inValid), .inReady(inReady),
        .mulDivControl(mulDivControl), .mulDivData1(mulDivData1), .mulDivData2(mulDivData2),
        .outValid(outValid), .outReady(outReady), .mulDivResult(mulDivResult),
        .busy(busy), .flush(flush)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Reference result from plain 64-bit integer arithmetic
    function automatic logic [31:0] refRes(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ua, ub, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'b0, a});
        ub = longint'({32'b0, b});
        if (!$onehot(op)) return 32'h0;
        if (op[0]) begin p = ua * ub; return p[31:0]; end
        if (op[1]) begin p = sa * sb; return p[63:32]; end
        if (op[2]) begin p = sa * ub; return p[63:32]; end
        if (op[3]) begin p = ua * ub; return p[63:32]; end
        if (b == 32'h0) return (op[4] || op[5]) ? 32'hFFFFFFFF : a;
        if (op[4]) r = sa / sb;
        else if (op[5]) r = ua / ub;
        else if (op[6]) r = sa % sb;
        else r = ua % ub;
        p = r;
        return p[31:0];
    endfunction

    function automatic int refLat(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] mag;
        int k;
        if (!$onehot(op)) return 1;
        if ((|op[7:4]) && b == 32'h0) return 1;
        if ((op[4] || op[6]) && a == 32'h80000000 && b == 32'hFFFFFFFF) return 1;
`ifdef MULDIV_EARLY_EXIT_EN
        if (|op[3:0]) begin
            mag = (op[1] && b[31]) ? -b : b;
            if (mag == 32'h0) return 2;
            k = 0;
            for (int i = 0; i < 32; i++) if (mag[i]) k = i;
            return k + 3;
        end
`else
        mag = b;
        k = int'(mag[0]);
`endif
        return 34;
    endfunction

    task automatic request(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        inValid = 1'b1; mulDivControl = op; mulDivData1 = a; mulDivData2 = b;
        @(posedge clk); #1;
        inValid = 1'b0;
        mulDivControl = 8'($urandom); mulDivData1 = $urandom; mulDivData2 = $urandom;
    endtask

    task automatic waitValid(output int lat);
        lat = 1;
        while (outValid !== 1'b1 && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic runOp(input string tag, input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
        int lat;
        request(op, a, b);
        waitValid(lat);
        check({tag, " result"}, mulDivResult, refRes(op, a, b));
        check({tag, " latency"}, 32'(lat), 32'(refLat(op, a, b)));
        @(posedge clk); #1;
        check({tag, " retire"}, {30'b0, inReady, outValid}, 32'b10);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat, seen, sel, kind;
        logic [7:0]  op;
        logic [31:0] a, b, held;

        rstn = 1'b0; inValid = 1'b0; outReady = 1'b1; flush = 1'b0;
        mulDivControl = 8'h0; mulDivData1 = 32'h0; mulDivData2 = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        check("reset inReady", {31'b0, inReady}, 32'd1);
        check("reset outValid", {31'b0, outValid}, 32'd0);
        check("reset busy", {31'b0, busy}, 32'd0);
        check("reset result", mulDivResult, 32'h0);
        @(negedge clk) rstn = 1'b1;

        runOp("MUL 7*-3", 8'h01, 32'd7, 32'hFFFFFFFD);
        runOp("MULH min*min", 8'h02, 32'h80000000, 32'h80000000);
        runOp("MULHU max*max", 8'h08, 32'hFFFFFFFF, 32'hFFFFFFFF);
        runOp("MULHSU -1*max", 8'h04, 32'hFFFFFFFF, 32'hFFFFFFFF);
        runOp("DIV -7/2", 8'h10, 32'hFFFFFFF9, 32'd2);
        runOp("REM -7/2", 8'h40, 32'hFFFFFFF9, 32'd2);
        runOp("DIVU 100/7", 8'h20, 32'd100, 32'd7);
        runOp("REMU 100/7", 8'h80, 32'd100, 32'd7);
        runOp("DIVU 5/0", 8'h20, 32'd5, 32'd0);
        runOp("REM 5/0", 8'h40, 32'd5, 32'd0);
        runOp("DIV overflow", 8'h10, 32'h80000000, 32'hFFFFFFFF);
        runOp("REM overflow", 8'h40, 32'h80000000, 32'hFFFFFFFF);
        runOp("DIVU min/-1", 8'h20, 32'h80000000, 32'hFFFFFFFF);
        runOp("not onehot", 8'h11, 32'd9, 32'd3);
        runOp("MUL 9*1", 8'h01, 32'd9, 32'd1);
        runOp("MULH x*0", 8'h02, 32'h12345678, 32'd0);

        // Backpressure: result must hold and new requests be ignored
        outReady = 1'b0;
        request(8'h08, 32'hFFFFFFFF, 32'hFFFFFFFF);
        waitValid(lat);
        check("bp first valid", {31'b0, outValid}, 32'd1);
        held = refRes(8'h08, 32'hFFFFFFFF, 32'hFFFFFFFF);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            inValid = 1'b1; mulDivControl = 8'h01; mulDivData1 = $urandom; mulDivData2 = $urandom;
            @(posedge clk); #1;
            check("bp hold result", mulDivResult, held);
            check("bp hold flags", {29'b0, inReady, outValid, busy}, 32'b011);
        end
        @(negedge clk);
        inValid = 1'b0; outReady = 1'b1;
        @(posedge clk); #1;
        check("bp retire", {30'b0, inReady, outValid}, 32'b10);

        // Flush during CALC iteration 5
        request(8'h20, 32'd1000, 32'd3);
        repeat (4) @(posedge clk);
        @(negedge clk) flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush calc idle", {30'b0, inReady, busy}, 32'b10);
        seen = 0;
        repeat (60) begin
            @(posedge clk); #1;
            if (outValid === 1'b1) seen++;
        end
        check("flush no outValid", 32'(seen), 32'd0);

        // Flush in DONE drops the result; flush in IDLE blocks an accept
        outReady = 1'b0;
        request(8'h20, 32'd5, 32'd0);
        check("special valid", {31'b0, outValid}, 32'd1);
        @(negedge clk) flush = 1'b1;
        @(posedge clk); #1;
        check("flush done", {29'b0, inReady, outValid, busy}, 32'b100);
        @(negedge clk); inValid = 1'b1; mulDivControl = 8'h01;
        @(posedge clk); #1;
        check("flush beats accept", {31'b0, busy}, 32'd0);
        @(negedge clk); flush = 1'b0; inValid = 1'b0; outReady = 1'b1;

        // Reset in the middle of a calculation
        request(8'h01, 32'd123, 32'd456);
        repeat (9) @(posedge clk);
        @(negedge clk) rstn = 1'b0;
        @(posedge clk); #1;
        check("midcalc rst flags", {29'b0, inReady, outValid, busy}, 32'b100);
        check("midcalc rst result", mulDivResult, 32'h0);
        @(negedge clk) rstn = 1'b1;

        for (int i = 0; i < 40; i++) begin
            sel = $urandom_range(0, 9);
            op = (sel < 8) ? 8'(1 << sel) : 8'($urandom);
            a = $urandom;
            b = $urandom;
            kind = $urandom_range(0, 7);
            if (kind == 0) b = 32'h0;
            else if (kind == 1) begin a = 32'h80000000; b = 32'hFFFFFFFF; end
            else if (kind == 2) b = 32'($urandom_range(0, 15));
            runOp($sformatf("rand%0d op%02h", i, op), op, a, b);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
